// File: rtl/wb_master_bridge.sv
// wb_master_bridge: Wishbone classic single-transfer master.
// Turns a valid/ready command stream into one Wishbone read or write cycle
// per command and returns one response beat carrying read data or a timeout
// error. Only one bus transaction is outstanding at any time.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   cmd_valid_i/ready_o    command handshake (ready is the only comb output)
//   cmd_we_i/adr_i/dat_i   command payload
//   rsp_valid_o/ready_i    response handshake
//   rsp_dat_o, rsp_err_o   response payload (data is 0 for writes/errors)
//   cyc_o, stb_o, we_o     Wishbone control
//   adr_o, dat_o, dat_i    Wishbone address / write data / read data
//   ack_i                  Wishbone acknowledge

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module wb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16          // must be >= 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                state_q,     state_nxt;
    logic [CNT_W-1:0]      cnt_q,       cnt_nxt;
    logic                  cyc_q,       cyc_nxt;
    logic                  stb_q,       stb_nxt;
    logic                  we_q,        we_nxt;
    logic [ADDR_WIDTH-1:0] adr_q,       adr_nxt;
    logic [DATA_WIDTH-1:0] dat_q,       dat_nxt;
    logic                  rsp_valid_q, rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_dat_q,   rsp_dat_nxt;
    logic                  rsp_err_q,   rsp_err_nxt;

    // Ready decodes state and reset so nothing is accepted while in reset.
    assign cmd_ready_o = rst_i && (state_q == ST_IDLE);

    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            cyc_q       <= cyc_nxt;
            stb_q       <= stb_nxt;
            we_q        <= we_nxt;
            adr_q       <= adr_nxt;
            dat_q       <= dat_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_dat_q   <= rsp_dat_nxt;
            rsp_err_q   <= rsp_err_nxt;
        end
    end

    // Next-state and next-output logic; everything holds by default.
    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        cyc_nxt       = cyc_q;
        stb_nxt       = stb_q;
        we_nxt        = we_q;
        adr_nxt       = adr_q;
        dat_nxt       = dat_q;
        rsp_valid_nxt = rsp_valid_q;
        rsp_dat_nxt   = rsp_dat_q;
        rsp_err_nxt   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_nxt    = cmd_we_i;
                    adr_nxt   = cmd_adr_i;
                    dat_nxt   = cmd_dat_i;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_REQUEST;
                end
            end

            ST_REQUEST: begin
                // Ack takes priority over a coincident timeout.
                if (ack_i) begin
                    rsp_dat_nxt   = we_q ? '0 : dat_i;
                    rsp_err_nxt   = 1'b0;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_dat_nxt   = '0;
                    rsp_err_nxt   = 1'b1;
                    cyc_nxt       = 1'b0;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_RESPOND;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            ST_RESPOND: begin
                // RESPOND plus the following IDLE cycle keep stb low >= 2 cycles.
                if (rsp_ready_i) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic single-transfer master sitting directly upstream of the team's Wishbone slave peripherals (e.g. the slave register). It converts a simple valid/ready command stream into one Wishbone read or write cycle per command and returns a single response beat. The response carries the read data, or an error flag if the addressed slave never acknowledges. Exactly one bus transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (8): Wishbone address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): Wishbone data width.
- `TIMEOUT`, default 16: number of cycles `stb_o` may stay high without `ack_i` before the cycle is aborted. Legal range is ≥ 4.

Ports:
- `clk_i` in 1: the single clock. All logic is on its rising edge.
- `rst_i` in 1: **synchronous, active-low** reset.
- `cmd_valid_i` in 1: a command is offered.
- `cmd_ready_o` out 1: the bridge accepts a command. Asserted only in IDLE while `rst_i` is high.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in ADDR_WIDTH: target address.
- `cmd_dat_i` in DATA_WIDTH: write data. Ignored for reads.
- `rsp_valid_o` out 1: a response is available.
- `rsp_ready_i` in 1: the consumer takes the response.
- `rsp_dat_o` out DATA_WIDTH: read data. 0 for writes and for errors.
- `rsp_err_o` out 1: the transfer timed out.
- `cyc_o`, `stb_o` out 1: Wishbone cycle and strobe.
- `we_o` out 1: Wishbone write enable.
- `adr_o` out ADDR_WIDTH: Wishbone address.
- `dat_o` out DATA_WIDTH: Wishbone write data.
- `dat_i` in DATA_WIDTH: Wishbone read data.
- `ack_i` in 1: Wishbone acknowledge.

## Operation
- State machine with three states: IDLE, REQUEST, RESPOND.
- **IDLE**
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i && cmd_ready_o`, register `cmd_we_i`, `cmd_adr_i` and `cmd_dat_i` onto `we_o`, `adr_o` and `dat_o`.
  - Set `cyc_o` and `stb_o` to 1, clear the timeout counter, and go to REQUEST.
- **REQUEST**
  - `cyc_o`, `stb_o`, `we_o`, `adr_o` and `dat_o` are held stable.
  - The counter increments every cycle in which `ack_i` is 0.
  - If `ack_i` is 1:
    - capture `rsp_dat_o` = `we_o` ? 0 : `dat_i`, and `rsp_err_o` = 0;
    - drop `cyc_o` and `stb_o`;
    - set `rsp_valid_o` and go to RESPOND.
  - Else if the counter equals `TIMEOUT-1`:
    - `rsp_dat_o` = 0, `rsp_err_o` = 1;
    - drop `cyc_o` and `stb_o`;
    - set `rsp_valid_o` and go to RESPOND.
  - If `ack_i` arrives in the same cycle as the timeout, `ack_i` wins.
- **RESPOND**
  - `cyc_o` = `stb_o` = 0.
  - Response outputs are held stable until `rsp_ready_i` = 1.
  - On that edge, clear `rsp_valid_o` and go to IDLE.
- `ack_i` is ignored outside REQUEST.
- `stb_o` is always low for at least 2 cycles between transactions. Slaves that clear their internal ack on a low strobe are therefore guaranteed to see it.
- **Reset:** while `rst_i` = 0 at a rising edge, the state becomes IDLE and all registered outputs return to 0. This holds from any state, including mid-REQUEST; the bus cycle is dropped without a response.
- Reset values: `cyc_o`, `stb_o`, `we_o`, `adr_o`, `dat_o`, `rsp_valid_o`, `rsp_dat_o` and `rsp_err_o` are all 0.
- `cmd_ready_o` is 0 combinationally whenever `rst_i` = 0.

## Timing
- All Wishbone outputs and all response outputs are registered. The only combinational output is `cmd_ready_o`, which decodes the state and `rst_i`.
- Command accepted at edge E0:
  - `cyc_o` and `stb_o` go high after E0.
  - `ack_i` is sampled at edges E1, E2, …
- If `ack_i` is first high at edge Ek:
  - `rsp_valid_o` goes high and `stb_o` goes low after Ek.
  - The earliest response is therefore 1 cycle after the command edge.
  - With the two-cycle-latency slave register, `ack_i` is first seen at E3, so `rsp_valid_o` rises after E3.
- No-ack case: `rsp_err_o` is asserted after edge E`TIMEOUT`.
- Throughput: at most one transaction per (k + 2) cycles when `rsp_ready_i` is tied high.

## Test plan
- **Write then read back, slave register DATA_WIDTH=8, `rsp_ready_i`=1.**
  - Issue write 0x5A to adr 0x03, then a read of adr 0x03.
  - Write response: `rsp_err_o`=0, `rsp_dat_o`=0x00.
  - Read response: `rsp_dat_o` = the slave's value, `rsp_err_o`=0.
  - `rsp_valid_o` rises exactly 3 cycles after each command handshake.
- **Backpressure.**
  - Hold `rsp_ready_i`=0 for 10 cycles after `rsp_valid_o` rises.
  - Response outputs are stable throughout, `cmd_ready_o`=0, `stb_o`=0.
  - The next command is accepted only in the cycle after the response handshake.
- **Timeout, TIMEOUT=16, `ack_i` tied 0.**
  - `rsp_err_o`=1 and `rsp_dat_o`=0 appear 16 cycles after command acceptance.
  - `stb_o` is low from the same cycle.
- **Ack and timeout coincide.**
  - Drive `ack_i`=1 with `dat_i`=0xC3 on the timeout cycle.
  - Expect `rsp_err_o`=0 and `rsp_dat_o`=0xC3.
- **Reset mid-REQUEST.**
  - Pull `rst_i` low 2 cycles after command acceptance.
  - After the next edge, `cyc_o`=`stb_o`=`rsp_valid_o`=0 and `cmd_ready_o`=0.
  - After release, `cmd_ready_o`=1 and no response is ever produced for the aborted command.
- **Stray ack.**
  - Pulse `ack_i` while in IDLE and while in RESPOND.
  - There is no state change and no extra response.
